operand_entry_fsm: RTL



---
 rtl/operand_entry_pkg.sv | 28 ++
 rtl/operand_entry_fsm_btn_debounce.sv | 49 ++++
 rtl/operand_entry_fsm.sv | 108 ++++++++++
 3 files changed

// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the operand entry front end: FSM state
// encodings, reset values and the debounce counter width helper.
package operand_entry_pkg;

    typedef enum logic [1:0] {
        S_X   = 2'd0,
        S_Y   = 2'd1,
        S_OP  = 2'd2,
        S_OUT = 2'd3
    } state_t;

    localparam state_t RST_STATE = S_X;
    localparam logic   RST_CTRL  = 1'b0;
    localparam logic   RST_VALID = 1'b0;

    // Bits needed to count 0 .. value-1; never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/operand_entry_fsm_btn_debounce.sv
// Push-button conditioning: two-flop synchronizer, stability debouncer and
// a registered one-cycle pulse on each accepted 0->1 level change.
module btn_debounce
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int            CW       = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_reg;
    logic          s2_reg;
    logic          level_reg;
    logic [CW-1:0] cnt_reg;
    logic          press_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
            press_reg <= 1'b0;
        end else begin
            s1_reg    <= btn;
            s2_reg    <= s1_reg;
            press_reg <= 1'b0;
            if (s2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Pulse is issued on the same edge the level flips, rising only.
                level_reg <= s2_reg;
                cnt_reg   <= '0;
                press_reg <= s2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/operand_entry_fsm.sv
// Operand entry front end: captures X, Y and add/sub control on successive
// button presses and offers them downstream via valid/ready.
// Optional cancel button enabled by defining OPERAND_ENTRY_CANCEL_EN.
module operand_entry_fsm
    import operand_entry_pkg::*;
#(
    parameter int DATA_W          = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
`ifdef OPERAND_ENTRY_CANCEL_EN
    input  logic              btn_cancel,
`endif
    input  logic [DATA_W-1:0] sw,
    input  logic              op_sw,
    output logic [DATA_W-1:0] out_x,
    output logic [DATA_W-1:0] out_y,
    output logic              out_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        state_dbg
);

    state_t            state_reg;
    logic [DATA_W-1:0] x_reg;
    logic [DATA_W-1:0] y_reg;
    logic              ctrl_reg;
    logic              valid_reg;
    logic              press;
    logic              cancel;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_press (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(press)
    );

`ifdef OPERAND_ENTRY_CANCEL_EN
    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cancel (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_cancel),
        .press(cancel)
    );
`else
    assign cancel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RST_STATE;
            x_reg     <= '0;
            y_reg     <= '0;
            ctrl_reg  <= RST_CTRL;
            valid_reg <= RST_VALID;
        end else begin
            case (state_reg)
                S_X: begin
                    if (press) begin
                        x_reg     <= sw;
                        state_reg <= S_Y;
                    end
                end
                S_Y: begin
                    if (cancel) begin
                        state_reg <= S_X;
                    end else if (press) begin
                        y_reg     <= sw;
                        state_reg <= S_OP;
                    end
                end
                S_OP: begin
                    if (cancel) begin
                        state_reg <= S_X;
                    end else if (press) begin
                        ctrl_reg  <= op_sw;
                        valid_reg <= 1'b1;
                        state_reg <= S_OUT;
                    end
                end
                S_OUT: begin
                    // Presses are deliberately dropped while the set is on offer.
                    if (valid_reg && out_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= S_X;
                    end
                end
                default: begin
                    state_reg <= S_X;
                end
            endcase
        end
    end

    assign out_x     = x_reg;
    assign out_y     = y_reg;
    assign out_ctrl  = ctrl_reg;
    assign out_valid = valid_reg;
    assign state_dbg = state_reg;

endmodule
